imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the CPU's 2048 x 32-bit instruction memory.
- Accepts a byte stream over a valid/ready handshake, fed by a UART receiver or a testbench.
- Parses a length header, assembles little-endian 32-bit words and writes them to sequential instruction-memory addresses starting at 0.
- Verifies a trailing XOR checksum, and holds the CPU in reset until a load completes cleanly.

Parameters:
- ADDR_W, 11, instruction-memory word-address width. Maximum load is 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle. A transfer occurs when in_valid && in_ready.
- start  input  1  single-cycle re-arm request. Honoured only in DONE or ERR.
- mem_we  output  1  instruction-memory write strobe, one-cycle pulse.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  32  write data.
- cpu_hold  output  1  high keeps the CPU in reset.
- done  output  1  load completed, checksum OK.
- err  output  1  load aborted: bad length or checksum mismatch.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state=HDR0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - cpu_hold=1, done=0, err=0;
  - byte index, word counter and checksum are all cleared.
- All outputs are registered. in_ready rises the first clk edge after rst_n deasserts.
- Stream format: count_lo, count_hi, then 4*N data bytes, then 1 checksum byte.
  - N = {count_hi,count_lo}, a 16-bit word count.
  - Each word's bytes arrive LSB first: the first byte goes to wdata[7:0].
  - The checksum is the XOR of all 4*N data bytes. Header bytes are excluded.
- States:
  - HDR0: on transfer, latch count_lo; go to HDR1.
  - HDR1: on transfer, form N.
    - N==0 or N>2**ADDR_W: go to ERR.
    - Otherwise go to DATA, with word counter=0 and byte index=0.
  - DATA: on each transfer, shift the byte into the assembler and XOR it into the checksum; byte index increments mod 4.
    - On the 4th byte of a word, the next cycle has mem_we=1, mem_addr=word counter and mem_wdata=the assembled word. The word counter then increments.
    - After the 4th byte of word N-1, go to CHK.
    - mem_addr holds its last value when mem_we=0.
  - CHK: on transfer, compare the byte with the running checksum.
    - Equal: go to DONE; done=1 and cpu_hold=0 in the next cycle.
    - Unequal: go to ERR; err=1 and cpu_hold stays 1.
  - DONE / ERR: in_ready=0 and the stream is ignored.
    - start=1 returns to HDR0 the next cycle: done=0, err=0, cpu_hold=1, checksum, counters and byte index cleared, in_ready=1.
- start in HDR0/HDR1/DATA/CHK is ignored.
- in_ready is 1 in HDR0, HDR1, DATA and CHK, including the cycle mem_we pulses. Back-to-back bytes at one per cycle are supported with no stalls.
- Gaps in in_valid freeze all state. in_data is sampled only on transfer.
- Words already written before an ERR are not rolled back.
- Reset mid-load aborts immediately. Memory contents are left as written, and the next load restarts from the header.
- Latency: the last data byte is accepted in cycle t; mem_we is high in cycle t+1.

Decomposition:
- Shared package imem_loader_pkg holds:
  - the state enum (HDR0, HDR1, DATA, CHK, DONE, ERR);
  - the header width constant HDR_W=16;
  - the bytes-per-word constant BPW=4.
- One natural sub-module, byte_packer:
  - a 4-byte little-endian shift assembler with a 2-bit index;
  - outputs word_valid and word;
  - clear input used on re-arm and reset.
- The FSM, counters and checksum stay in imem_loader.

Test Plan:
- Nominal 2-word load, bytes 02 00 78 56 34 12 EF BE AD DE 2A at one per cycle -> two writes: addr0=0x12345678, addr1=0xDEADBEEF. done=1, err=0, cpu_hold=0, in_ready=0 afterwards.
- Same stream with checksum 2B -> both writes occur, then err=1, done=0, cpu_hold=1.
- Header 01 08 (N=2049) -> err=1 the cycle after the 2nd byte, no mem_we. Header 00 00 -> same result.
- Nominal stream with random 0-5 cycle in_valid gaps, and in_valid asserted while in_ready=0 in DONE -> identical writes and flags; the extra bytes are ignored.
- rst_n pulsed low after 5 data bytes of a 2-word load -> all outputs at reset values at once. The full nominal stream then completes with done=1.
- start pulsed mid-DATA has no effect. start pulsed in DONE -> cpu_hold=1, done=0, in_ready=1; a second 1-word load (01 00 04 03 02 01 04) writes addr0=0x01020304 and sets done=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and constants for the boot-time instruction-memory loader:
//   the loader FSM state encoding, the stream header width, the number of
//   bytes per instruction word and small helpers for the running checksum.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  // Word-count header is two bytes, low byte first.
  localparam int HDR_W = 16;
  // Bytes per 32-bit instruction word.
  localparam int BPW   = 4;

  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Running XOR checksum over the data bytes.
  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

  // States in which the loader consumes stream bytes.
  function automatic logic is_loading(input state_e s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
//   Little-endian 4-byte word assembler. The first byte of a word ends up in
//   word_o[7:0]. word_valid_o/word_o are combinational and describe the word
//   completed by the byte presented this cycle, so the parent can register
//   the memory write in the same edge that accepts the last byte.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear_i        synchronous clear of byte index and partial word
//   byte_valid_i   byte_i is consumed this cycle
//   byte_i         stream byte
//   word_valid_o   this byte completes a word
//   word_o         completed word (valid with word_valid_o)
// ---------------------------------------------------------------------------
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_IDX = 2'(BPW - 1);

  logic [1:0]  idx_q, idx_d;
  // Only the first three bytes need storage; the fourth is taken live.
  logic [23:0] shift_q, shift_d;

  // Next-state for byte index and partial-word shift register.
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear_i) begin
      idx_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid_i) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {byte_i, shift_q[23:8]};
    end else begin
      idx_d   = idx_q;
      shift_d = shift_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  assign word_valid_o = byte_valid_i && !clear_i && (idx_q == LAST_IDX);
  assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time writer for the CPU instruction memory. Consumes a byte stream
//   (count_lo, count_hi, 4*N little-endian data bytes, XOR checksum), writes
//   the words to addresses 0..N-1 and releases the CPU from reset only after
//   a load whose checksum matches. All outputs are registered.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_data    stream byte offer
//   in_ready            byte accepted when in_valid && in_ready
//   start               re-arm request, honoured only in DONE or ERR
//   mem_we/addr/wdata   one-cycle instruction-memory write
//   cpu_hold            keeps the CPU in reset
//   done / err          load completed cleanly / load aborted
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned MAX_N = 2 ** ADDR_W;

  state_e             state_q, state_d;
  logic [7:0]         cnt_lo_q, cnt_lo_d;
  logic [ADDR_W-1:0]  last_q, last_d;        // index of the final word (N-1)
  logic [ADDR_W-1:0]  word_cnt_q, word_cnt_d;
  logic [7:0]         csum_q, csum_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic               in_ready_q, in_ready_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               xfer_s;
  logic [HDR_W-1:0]   n_s;
  logic               pk_clear_s;
  logic               pk_valid_s;
  logic               pk_word_valid_s;
  logic [31:0]        pk_word_s;

  assign xfer_s     = in_valid && in_ready_q;
  assign n_s        = {in_data, cnt_lo_q};
  assign pk_valid_s = xfer_s && (state_q == ST_DATA);

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (pk_clear_s),
    .byte_valid_i (pk_valid_s),
    .byte_i       (in_data),
    .word_valid_o (pk_word_valid_s),
    .word_o       (pk_word_s)
  );

  // Loader FSM, counters, checksum and next-cycle output values.
  always_comb begin
    state_d     = state_q;
    cnt_lo_d    = cnt_lo_q;
    last_d      = last_q;
    word_cnt_d  = word_cnt_q;
    csum_d      = csum_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    pk_clear_s  = 1'b0;

    case (state_q)
      ST_HDR0: begin
        if (xfer_s) begin
          cnt_lo_d = in_data;
          state_d  = ST_HDR1;
        end else begin
          state_d  = ST_HDR0;
        end
      end
      ST_HDR1: begin
        if (xfer_s) begin
          if ((n_s == 16'd0) || (32'(n_s) > MAX_N)) begin
            state_d = ST_ERR;
          end else begin
            state_d    = ST_DATA;
            last_d     = ADDR_W'(n_s - 16'd1);
            word_cnt_d = '0;
            csum_d     = 8'd0;
            pk_clear_s = 1'b1;
          end
        end else begin
          state_d = ST_HDR1;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          csum_d = csum_next(csum_q, in_data);
          if (pk_word_valid_s) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q;
            mem_wdata_d = pk_word_s;
            word_cnt_d  = word_cnt_q + ADDR_W'(1);
            // Word counter wraps after the final word; CHK never looks at it.
            if (word_cnt_q == last_q) begin
              state_d = ST_CHK;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CHK: begin
        if (xfer_s) begin
          state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
        end else begin
          state_d = ST_CHK;
        end
      end
      ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_HDR0;
          cnt_lo_d   = 8'd0;
          word_cnt_d = '0;
          csum_d     = 8'd0;
          pk_clear_s = 1'b1;
        end else begin
          state_d    = state_q;
        end
      end
      default: begin
        // Unreachable encoding: park in ERR so the CPU stays held.
        state_d = ST_ERR;
      end
    endcase

    in_ready_d = is_loading(state_d);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
    cpu_hold_d = (state_d != ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HDR0;
      cnt_lo_q    <= 8'd0;
      last_q      <= '0;
      word_cnt_q  <= '0;
      csum_q      <= 8'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_we_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      last_q      <= last_d;
      word_cnt_q  <= word_cnt_d;
      csum_q      <= csum_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      in_ready_q  <= in_ready_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Streams are built from word lists by
//   a reference model (little-endian byte split, XOR checksum, expected write
//   queue); a monitor compares every mem_we pulse against that queue and the
//   flags are checked after each load.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              start = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && mem_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        check("wr_addr", 32'(mem_addr), exp_addr_q.pop_front());
        check("wr_data", mem_wdata, exp_data_q.pop_front());
      end
    end
  end

  // Reference model: build the byte stream and the expected writes.
  task automatic build(input logic [31:0] words[$], input bit bad_csum,
                       output logic [7:0] s[$]);
    logic [7:0]  cs;
    logic [15:0] n;
    logic [7:0]  b;
    cs = 8'd0;
    n  = 16'(words.size());
    s  = {};
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    for (int i = 0; i < words.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(words[i] >> (8 * k));
        s.push_back(b);
        cs = cs ^ b;
      end
      exp_addr_q.push_back(32'(i));
      exp_data_q.push_back(words[i]);
    end
    if (bad_csum) cs = cs ^ 8'h01;
    s.push_back(cs);
  endtask

  // Drive a byte stream; gaps of 0..gap_max idle cycles, optional start pulse.
  task automatic send(input logic [7:0] s[$], input int gap_max, input int start_idx);
    int guard;
    int gap;
    for (int i = 0; i < s.size(); i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = s[i];
      start    = (i == start_idx);
      guard    = 0;
      while (in_ready !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        check("ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_flags(input string tag, input bit exp_done, input bit exp_err,
                             input bit exp_hold, input bit exp_ready);
    check({tag, "_done"},  32'(done),     32'(exp_done));
    check({tag, "_err"},   32'(err),      32'(exp_err));
    check({tag, "_hold"},  32'(cpu_hold), 32'(exp_hold));
    check({tag, "_ready"}, 32'(in_ready), 32'(exp_ready));
  endtask

  task automatic check_reset_vals(input string tag);
    check_flags(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    check({tag, "_we"},    32'(mem_we),   32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, mem_wdata,     32'd0);
  endtask

  task automatic rearm(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_flags(tag, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic drain_check(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q = {};
    exp_data_q = {};
  endtask

  initial begin
    logic [31:0] words[$];
    logic [7:0]  s[$];
    bit          bad;
    int          nw;

    // Reset
    #1 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    check("ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Nominal 2-word load
    words = '{32'h1234_5678, 32'hDEAD_BEEF};
    build(words, 1'b0, s);
    check("nominal_csum_byte", 32'(s[s.size()-1]), 32'h2A);
    send(s, 0, -1);
    check_flags("nominal", 1'b1, 1'b0, 1'b0, 1'b0);
    drain_check("nominal");
    rearm("rearm1");

    // Bad checksum: writes still happen, then ERR
    build(words, 1'b1, s);
    send(s, 0, -1);
    check_flags("badcsum", 1'b0, 1'b1, 1'b1, 1'b0);
    drain_check("badcsum");
    rearm("rearm2");

    // N = 2049: too long
    s = '{8'h01, 8'h08};
    send(s, 0, -1);
    check_flags("n2049", 1'b0, 1'b1, 1'b1, 1'b0);
    drain_check("n2049");
    rearm("rearm3");

    // N = 0
    s = '{8'h00, 8'h00};
    send(s, 0, -1);
    check_flags("n0", 1'b0, 1'b1, 1'b1, 1'b0);
    drain_check("n0");
    rearm("rearm4");

    // Nominal with gaps, then stream bytes offered in DONE are ignored
    build(words, 1'b0, s);
    send(s, 5, -1);
    check_flags("gaps", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
      check("done_ignores_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check_flags("done_ignore", 1'b1, 1'b0, 1'b0, 1'b0);
    drain_check("gaps");
    rearm("rearm5");

    // Reset after 5 data bytes: word 0 written, then everything aborts
    build(words, 1'b0, s);
    exp_addr_q = '{32'd0};
    exp_data_q = '{32'h1234_5678};
    s = s[0:6];
    send(s, 0, -1);
    rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    check("midreset_writes_left", 32'(exp_addr_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build(words, 1'b0, s);
    send(s, 0, -1);
    check_flags("after_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    drain_check("after_reset");

    // start during DATA is ignored; start in DONE re-arms for a 1-word load
    rearm("rearm6");
    build(words, 1'b0, s);
    send(s, 0, 5);
    check_flags("start_mid", 1'b1, 1'b0, 1'b0, 1'b0);
    drain_check("start_mid");
    rearm("rearm7");
    words = '{32'h0102_0304};
    build(words, 1'b0, s);
    check("oneword_csum_byte", 32'(s[s.size()-1]), 32'h04);
    send(s, 0, -1);
    check_flags("oneword", 1'b1, 1'b0, 1'b0, 1'b0);
    drain_check("oneword");

    // Randomized loads
    for (int it = 0; it < 10; it++) begin
      rearm("rearm_rand");
      nw    = int'($urandom_range(1, 6));
      words = {};
      for (int i = 0; i < nw; i++) words.push_back($urandom);
      bad = ($urandom_range(0, 2) == 0);
      build(words, bad, s);
      send(s, (it % 2 == 0) ? 0 : 5, int'($urandom_range(3, 5)));
      check_flags("rand", !bad, bad, bad, 1'b0);
      drain_check("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
